// File: rtl/count_wrap_pkg.sv
// -----------------------------------------------------------------------------
// count_wrap_pkg
// Shared types and helpers for count_wrap_monitor.
//   state_t : monitor FSM states (INIT captures a reference, TRACK classifies)
//   step_t  : per-cycle classification of a count transition
//   mod_inc / mod_dec : +1 / -1 modulo n, used to predict legal next counts
// -----------------------------------------------------------------------------
package count_wrap_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STEP_UP = 2'd1,
        STEP_DN = 2'd2,
        JUMP    = 2'd3
    } step_t;

    // (value + 1) mod n. The monitored count is at most 2^W-1 <= 2n-2, so a
    // single conditional subtraction fully reduces the sum.
    function automatic logic [31:0] mod_inc(input logic [31:0] value,
                                            input logic [31:0] n);
        logic [31:0] sum;
        sum = value + 32'd1;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

    // (value + n - 1) mod n. With value <= 2n-2 the sum stays below 3n, so two
    // conditional subtractions fully reduce it.
    function automatic logic [31:0] mod_dec(input logic [31:0] value,
                                            input logic [31:0] n);
        logic [31:0] sum;
        sum = value + n - 32'd1;
        sum = (sum >= n) ? (sum - n) : sum;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/wrap_period_timer.sv
// -----------------------------------------------------------------------------
// wrap_period_timer
// Measures the number of clock cycles between consecutive wraps.
// A free-running saturating timer restarts at 1 on every wrap, so at the next
// wrap it holds exactly the cycle distance between the two wraps. The first
// wrap after reset/clr only arms the measurement.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   clr          in   synchronous clear: zero period, disarm
//   wrap         in   a wrap is being registered on this edge
//   period       out  [PW] cycles between the last two wraps (registered)
//   period_valid out  one-cycle pulse aligned with the wrap pulse
// -----------------------------------------------------------------------------
module wrap_period_timer #(
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wrap,
    output logic [PW-1:0] period,
    output logic          period_valid
);

    localparam logic [PW-1:0] TIMER_MAX = {PW{1'b1}};
    localparam logic [PW-1:0] TIMER_ONE = PW'(32'd1);

    logic [PW-1:0] timer_r;
    logic [PW-1:0] timer_nxt_s;
    logic          armed_r;
    logic          armed_nxt_s;
    logic [PW-1:0] period_nxt_s;
    logic          period_valid_nxt_s;

    // Next-state logic for timer, arming flag and latched period.
    always_comb begin
        timer_nxt_s        = timer_r;
        armed_nxt_s        = armed_r;
        period_nxt_s       = period;
        period_valid_nxt_s = 1'b0;
        if (clr) begin
            timer_nxt_s  = {PW{1'b0}};
            armed_nxt_s  = 1'b0;
            period_nxt_s = {PW{1'b0}};
        end else if (wrap) begin
            timer_nxt_s = TIMER_ONE;
            armed_nxt_s = 1'b1;
            if (armed_r) begin
                period_nxt_s       = timer_r;
                period_valid_nxt_s = 1'b1;
            end else begin
                period_nxt_s = period;
            end
        end else if (timer_r != TIMER_MAX) begin
            timer_nxt_s = timer_r + TIMER_ONE;
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r      <= {PW{1'b0}};
            armed_r      <= 1'b0;
            period       <= {PW{1'b0}};
            period_valid <= 1'b0;
        end else begin
            timer_r      <= timer_nxt_s;
            armed_r      <= armed_nxt_s;
            period       <= period_nxt_s;
            period_valid <= period_valid_nxt_s;
        end
    end

endmodule

// File: rtl/count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// count_wrap_monitor
// Passive observer of a mod-N up/down counter. Every cycle it classifies the
// transition prev_count -> count_in as HOLD, STEP_UP, STEP_DN or JUMP, emits
// one-cycle wrap and direction-change pulses, keeps a saturating wrap tally and
// a sticky illegal-jump flag. All outputs are registered.
// Optional build macro: COUNT_WRAP_PERIOD_EN adds period / period_valid
// (cycles between consecutive wraps).
// Ports:
//   clk          in   clock shared with the counter
//   rst          in   asynchronous active-high reset
//   count_in     in   [W] monitored counter value
//   up_down      in   counter direction (1 = up)
//   clr          in   synchronous clear of statistics, re-arms (INIT)
//   wrap_up      out  pulse: N-1 -> 0 seen
//   wrap_dn      out  pulse: 0 -> N-1 seen
//   dir_change   out  pulse: up_down toggled
//   wrap_cnt     out  [WRAPW] saturating wrap tally
//   wrap_sat     out  sticky: wrap_cnt reached its maximum
//   err_jump     out  sticky: illegal transition seen
//   period       out  [PW] cycles between wraps (COUNT_WRAP_PERIOD_EN only)
//   period_valid out  pulse with a new period (COUNT_WRAP_PERIOD_EN only)
// -----------------------------------------------------------------------------
module count_wrap_monitor
    import count_wrap_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned W     = $clog2(N),
    parameter int unsigned WRAPW = 8
`ifdef COUNT_WRAP_PERIOD_EN
    ,
    parameter int unsigned PW    = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     count_in,
    input  logic             up_down,
    input  logic             clr,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             dir_change,
    output logic [WRAPW-1:0] wrap_cnt,
    output logic             wrap_sat,
    output logic             err_jump
`ifdef COUNT_WRAP_PERIOD_EN
    ,
    output logic [PW-1:0]    period,
    output logic             period_valid
`endif
);

    localparam logic [W-1:0]     LAST_COUNT = W'(N - 32'd1);
    localparam logic [W-1:0]     ZERO_COUNT = {W{1'b0}};
    localparam logic [WRAPW-1:0] WRAP_MAX   = {WRAPW{1'b1}};
    localparam logic [WRAPW-1:0] WRAP_ONE   = WRAPW'(32'd1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [W-1:0]     prev_count_r;
    logic [W-1:0]     prev_count_nxt_s;
    logic             prev_dir_r;
    logic             prev_dir_nxt_s;

    // Predictions are kept 32 bits wide so a count at 2^W-1 never aliases
    // back to 0 the way a W-bit increment would.
    logic [31:0]      count_ext_s;
    logic [31:0]      inc_s;
    logic [31:0]      dec_s;
    step_t            step_s;

    logic             wrap_up_nxt_s;
    logic             wrap_dn_nxt_s;
    logic             dir_change_nxt_s;
    logic [WRAPW-1:0] wrap_cnt_nxt_s;
    logic             wrap_sat_nxt_s;
    logic             err_jump_nxt_s;

    assign count_ext_s = 32'(count_in);
    assign inc_s       = mod_inc(32'(prev_count_r), N);
    assign dec_s       = mod_dec(32'(prev_count_r), N);

    // Classify the transition prev_count -> count_in. HOLD is checked first,
    // so a counter parked at any value (even >= N) raises no event.
    always_comb begin
        step_s = JUMP;
        if (count_in == prev_count_r) begin
            step_s = HOLD;
        end else if (count_ext_s == inc_s) begin
            step_s = STEP_UP;
        end else if (count_ext_s == dec_s) begin
            step_s = STEP_DN;
        end else begin
            step_s = JUMP;
        end
    end

    // FSM next state, reference update and next values of all outputs.
    always_comb begin
        state_nxt_s      = state_r;
        prev_count_nxt_s = prev_count_r;
        prev_dir_nxt_s   = prev_dir_r;
        wrap_up_nxt_s    = 1'b0;
        wrap_dn_nxt_s    = 1'b0;
        dir_change_nxt_s = 1'b0;
        wrap_cnt_nxt_s   = wrap_cnt;
        wrap_sat_nxt_s   = wrap_sat;
        err_jump_nxt_s   = err_jump;
        if (clr) begin
            // The sample on the clr edge is discarded; INIT recaptures.
            state_nxt_s      = INIT;
            prev_count_nxt_s = ZERO_COUNT;
            prev_dir_nxt_s   = 1'b0;
            wrap_cnt_nxt_s   = {WRAPW{1'b0}};
            wrap_sat_nxt_s   = 1'b0;
            err_jump_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    state_nxt_s      = TRACK;
                    prev_count_nxt_s = count_in;
                    prev_dir_nxt_s   = up_down;
                end
                TRACK: begin
                    wrap_up_nxt_s    = (step_s == STEP_UP) && (prev_count_r == LAST_COUNT);
                    wrap_dn_nxt_s    = (step_s == STEP_DN) && (prev_count_r == ZERO_COUNT);
                    dir_change_nxt_s = (up_down != prev_dir_r);
                    err_jump_nxt_s   = err_jump || (step_s == JUMP);
                    if ((wrap_up_nxt_s || wrap_dn_nxt_s) && (wrap_cnt != WRAP_MAX)) begin
                        wrap_cnt_nxt_s = wrap_cnt + WRAP_ONE;
                    end else begin
                        wrap_cnt_nxt_s = wrap_cnt;
                    end
                    wrap_sat_nxt_s   = wrap_sat || (wrap_cnt_nxt_s == WRAP_MAX);
                    // Always follow the counter, even after a jump, so
                    // tracking resynchronises on the next cycle.
                    prev_count_nxt_s = count_in;
                    prev_dir_nxt_s   = up_down;
                end
                default: begin
                    state_nxt_s = INIT;
                end
            endcase
        end
    end

    // State, reference and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= INIT;
            prev_count_r <= ZERO_COUNT;
            prev_dir_r   <= 1'b0;
            wrap_up      <= 1'b0;
            wrap_dn      <= 1'b0;
            dir_change   <= 1'b0;
            wrap_cnt     <= {WRAPW{1'b0}};
            wrap_sat     <= 1'b0;
            err_jump     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            prev_count_r <= prev_count_nxt_s;
            prev_dir_r   <= prev_dir_nxt_s;
            wrap_up      <= wrap_up_nxt_s;
            wrap_dn      <= wrap_dn_nxt_s;
            dir_change   <= dir_change_nxt_s;
            wrap_cnt     <= wrap_cnt_nxt_s;
            wrap_sat     <= wrap_sat_nxt_s;
            err_jump     <= err_jump_nxt_s;
        end
    end

`ifdef COUNT_WRAP_PERIOD_EN
    logic wrap_evt_s;

    assign wrap_evt_s = wrap_up_nxt_s || wrap_dn_nxt_s;

    wrap_period_timer #(
        .PW (PW)
    ) u_period_timer (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .wrap         (wrap_evt_s),
        .period       (period),
        .period_valid (period_valid)
    );
`endif

endmodule

// File: tb/tb_count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_wrap_monitor
// Drives count_wrap_monitor (N=12, WRAPW=3) with directed and random counter
// traffic. A reference model computes the expected registered outputs for
// each edge and queues them; a monitor pops one entry per edge and compares.
// -----------------------------------------------------------------------------
module tb_count_wrap_monitor;

    localparam int N     = 12;
    localparam int W     = 4;
    localparam int WRAPW = 3;
    localparam int MAXC  = 7;
    localparam int PMAX  = 65535;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     count_in;
    logic             up_down;
    logic             clr;
    logic             wrap_up;
    logic             wrap_dn;
    logic             dir_change;
    logic [WRAPW-1:0] wrap_cnt;
    logic             wrap_sat;
    logic             err_jump;
`ifdef COUNT_WRAP_PERIOD_EN
    logic [15:0]      period;
    logic             period_valid;
`endif

    always #5 clk = ~clk;

    count_wrap_monitor #(
        .N     (N),
        .WRAPW (WRAPW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .up_down    (up_down),
        .clr        (clr),
        .wrap_up    (wrap_up),
        .wrap_dn    (wrap_dn),
        .dir_change (dir_change),
        .wrap_cnt   (wrap_cnt),
        .wrap_sat   (wrap_sat),
        .err_jump   (err_jump)
`ifdef COUNT_WRAP_PERIOD_EN
        ,
        .period       (period),
        .period_valid (period_valid)
`endif
    );

    typedef struct {
        bit wu;
        bit wd;
        bit dc;
        int cnt;
        bit sat;
        bit err;
        int per;
        bit pv;
    } exp_t;

    exp_t q[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state (specification-level view of the monitor).
    bit m_armed;
    int m_prev;
    bit m_dir;
    int m_cnt;
    bit m_sat;
    bit m_err;
    int m_edge;
    bit m_have_wrap;
    int m_last_wrap;
    int m_period;

    int c_cur;
    bit ud_cur;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed     = 1'b0;
        m_prev      = 0;
        m_dir       = 1'b0;
        m_cnt       = 0;
        m_sat       = 1'b0;
        m_err       = 1'b0;
        m_have_wrap = 1'b0;
        m_last_wrap = 0;
        m_period    = 0;
    endtask

    // Apply inputs for the coming edge and queue the outputs it should produce.
    task automatic drive(input int c, input bit ud, input bit cl);
        exp_t e;
        bit up, dn, hold;
        count_in = W'(c);
        up_down  = ud;
        clr      = cl;
        e = '{default: 0};
        m_edge++;
        if (cl) begin
            model_reset();
        end else if (!m_armed) begin
            m_armed = 1'b1;
            m_prev  = c;
            m_dir   = ud;
        end else begin
            hold = (c == m_prev);
            up   = (c == (m_prev + 1) % N);
            dn   = (c == (m_prev + N - 1) % N);
            e.wu = up && (m_prev == N - 1);
            e.wd = dn && (m_prev == 0);
            e.dc = (ud != m_dir);
            if (!hold && !up && !dn) m_err = 1'b1;
            if (e.wu || e.wd) begin
                if (m_cnt < MAXC) m_cnt++;
                if (m_cnt == MAXC) m_sat = 1'b1;
                if (m_have_wrap) begin
                    m_period = (m_edge - m_last_wrap > PMAX) ? PMAX : (m_edge - m_last_wrap);
                    e.pv     = 1'b1;
                end
                m_have_wrap = 1'b1;
                m_last_wrap = m_edge;
            end
            m_prev = c;
            m_dir  = ud;
        end
        e.cnt = m_cnt;
        e.sat = m_sat;
        e.err = m_err;
        e.per = m_period;
        q.push_back(e);
    endtask

    task automatic step(input int c, input bit ud, input bit cl);
        @(negedge clk);
        drive(c, ud, cl);
    endtask

    // Move the modelled counter n legal steps in direction ud.
    task automatic run(input int n, input bit ud);
        for (int i = 0; i < n; i++) begin
            c_cur  = ud ? (c_cur + 1) % N : (c_cur + N - 1) % N;
            ud_cur = ud;
            step(c_cur, ud, 1'b0);
        end
    endtask

    // Monitor: one queued expectation per edge, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("wrap_up",    int'(wrap_up),    int'(e.wu));
            check("wrap_dn",    int'(wrap_dn),    int'(e.wd));
            check("dir_change", int'(dir_change), int'(e.dc));
            check("wrap_cnt",   int'(wrap_cnt),   e.cnt);
            check("wrap_sat",   int'(wrap_sat),   int'(e.sat));
            check("err_jump",   int'(err_jump),   int'(e.err));
`ifdef COUNT_WRAP_PERIOD_EN
            check("period",       int'(period),       e.per);
            check("period_valid", int'(period_valid), int'(e.pv));
`endif
        end
    end

    initial begin
        int r;
        rst      = 1'b1;
        clr      = 1'b0;
        up_down  = 1'b1;
        count_in = '0;
        m_edge   = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_wrap_up",  int'(wrap_up),  0);
        check("rst_wrap_dn",  int'(wrap_dn),  0);
        check("rst_dir_chg",  int'(dir_change), 0);
        check("rst_wrap_cnt", int'(wrap_cnt), 0);
        check("rst_wrap_sat", int'(wrap_sat), 0);
        check("rst_err_jump", int'(err_jump), 0);

        // Release with count 0 counting up; run through an up wrap.
        @(negedge clk);
        rst    = 1'b0;
        c_cur  = 0;
        ud_cur = 1'b1;
        drive(0, 1'b1, 1'b0);
        run(14, 1'b1);
        // Down through a down wrap (dir_change on the first step).
        run(4, 1'b0);
        // Up to 7, then direction flips while the count holds, then steps down.
        run(9, 1'b1);
        step(7, 1'b0, 1'b0);
        run(1, 1'b0);
        // Reach 3, then jump to 9 and continue legally.
        run(3, 1'b0);
        step(9, 1'b1, 1'b0);
        step(10, 1'b1, 1'b0);
        step(11, 1'b1, 1'b0);
        // clr, then a transition that would be a jump but is INIT.
        step(11, 1'b1, 1'b1);
        step(5, 1'b1, 1'b0);
        step(6, 1'b1, 1'b0);
        // Out-of-range counts are jumps; parked out-of-range value holds.
        step(13, 1'b1, 1'b0);
        step(14, 1'b1, 1'b0);
        step(14, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1);
        // Counter held in its own reset: no events.
        repeat (5) step(0, 1'b1, 1'b0);
        c_cur = 0;
        // Nine up wraps: tally saturates at 7.
        run(12 * 9, 1'b1);

        // Random walk with occasional jumps, holds, direction flips and clr.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(c_cur, ud_cur, 1'b1);
            end else if (r < 7) begin
                c_cur = $urandom_range(0, 15);
                step(c_cur, ud_cur, 1'b0);
                c_cur = c_cur % N;
            end else if (r < 20) begin
                ud_cur = ~ud_cur;
                step(c_cur, ud_cur, 1'b0);
            end else if (r < 30) begin
                step(c_cur, ud_cur, 1'b0);
            end else begin
                run(1, ud_cur);
            end
        end

        // Produce a wrap pulse, then reset asynchronously while it is high.
        step(11, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_wrap_up", int'(wrap_up), 1);
        rst      = 1'b1;
        count_in = W'(11);
        #1;
        check("async_rst_wrap_up",  int'(wrap_up),  0);
        check("async_rst_wrap_cnt", int'(wrap_cnt), 0);
        check("async_rst_err_jump", int'(err_jump), 0);
        model_reset();
        repeat (2) @(negedge clk);
        // Released with count 11 during reset; first sample 0 is INIT only.
        rst    = 1'b0;
        c_cur  = 0;
        ud_cur = 1'b1;
        drive(0, 1'b1, 1'b0);
        run(13, 1'b1);

        @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/count_wrap_monitor.md
Name: count_wrap_monitor

Overview:
- Sits directly downstream of the mod-N up/down counter. Taps its count and up_down lines.
- Classifies every cycle's count transition and flags wraps (N-1->0 up, 0->N-1 down), direction reversals and illegal jumps.
- Keeps a saturating wrap tally for status and interrupt logic.
- Purely observational; never drives the counter.

Parameters:
- N, 16, counter modulus; legal range N >= 3 (for N = 2, +1 and -1 are indistinguishable).
- W, $clog2(N), width of count_in.
- WRAPW, 8, width of wrap_cnt.
- PW, 16, width of period (optional feature only).

Ports:
- clk  input  1  rising-edge clock, same clock as the counter.
- rst  input  1  asynchronous, active-high reset.
- count_in  input  W  counter output being monitored.
- up_down  input  1  counter direction (1 = up, 0 = down).
- clr  input  1  synchronous clear of statistics; also re-arms.
- wrap_up  output  1  one-cycle pulse: up wrap seen.
- wrap_dn  output  1  one-cycle pulse: down wrap seen.
- dir_change  output  1  one-cycle pulse: up_down toggled.
- wrap_cnt  output  WRAPW  total wraps (up + down), saturating.
- wrap_sat  output  1  sticky: wrap_cnt has saturated.
- err_jump  output  1  sticky: illegal transition seen.

Behaviour:
- Reset: all outputs 0, prev_count = 0, prev_dir = 0, FSM = INIT. Reset is asynchronous, active-high, highest priority.
- FSM has two states:
  - INIT: on the next edge, capture count_in into prev_count and up_down into prev_dir, go to TRACK. No pulses and no error in this state.
  - TRACK: every edge, classify (prev_count -> count_in), then update prev_count and prev_dir.
- Classification, all arithmetic modulo N on W+1 bits with no wrap artefacts at 2^W:
  - HOLD: count_in == prev_count.
  - STEP_UP: count_in == (prev_count + 1) mod N.
  - STEP_DN: count_in == (prev_count + N - 1) mod N.
  - JUMP: anything else, including count_in >= N.
- Wrap flags:
  - wrap_up = STEP_UP with prev_count == N-1.
  - wrap_dn = STEP_DN with prev_count == 0.
- Direction is not cross-checked against the step. Step direction alone determines the wrap type.
- Pulse timing: outputs are registered. A transition sampled at edge k drives its pulse high from edge k to edge k+1 (one cycle). Pulses are never stretched; back-to-back events give back-to-back pulses.
- dir_change: in TRACK when up_down != prev_dir. It can coincide with a wrap; both pulse.
- wrap_cnt: +1 on wrap_up or wrap_dn (mutually exclusive). Holds at 2^WRAPW-1; wrap_sat sets on the edge that reaches max and stays set.
- err_jump: set on any JUMP in TRACK; sticky. prev_count still updates to count_in so tracking resynchronises.
- Priority: rst > clr > normal.
- clr: next edge zeroes wrap_cnt, wrap_sat, err_jump and all pulses, and forces INIT. The sample taken on the clr edge is discarded.
- Counter held in its own reset (count_in stuck at 0) is HOLD: no events.
- Reset mid-operation clears any in-flight pulse immediately. The first post-reset transition is never classified (INIT), even if it is N-1 -> 0.

Optional Feature:
- Macro: COUNT_WRAP_PERIOD_EN.
- Defined:
  - Adds outputs period[PW] and period_valid[1].
  - A free-running cycle timer restarts on every wrap.
  - On each wrap after the first since reset or clr, period latches the cycles since the previous wrap, and period_valid pulses one cycle, aligned with wrap_up/wrap_dn.
  - The timer saturates at 2^PW-1.
  - rst/clr zero period and disarm the first-wrap qualifier.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package count_wrap_pkg holds:
  - state enum {INIT, TRACK}
  - step-class enum {HOLD, STEP_UP, STEP_DN, JUMP}
  - helper functions mod_inc / mod_dec, parameterised by N
- One sub-module is natural: wrap_period_timer (saturating cycle counter plus latch), instantiated only under COUNT_WRAP_PERIOD_EN.

Test Plan:
- N=16, release rst with count 0 and up_down=1, counter runs up 0..15,0 -> wrap_up high for exactly one cycle after count 0 is sampled; wrap_cnt=1; wrap_dn=0; err_jump=0.
- Count at 2, up_down=0, counter runs down 2,1,0,15 -> wrap_dn single pulse after 15 sampled; wrap_cnt increments by 1.
- Up-counting reaches 7, up_down driven to 0 -> dir_change one pulse; no wrap; count then 6 classified STEP_DN; err_jump=0.
- Force count_in 3 -> 9, then 10, 11 -> err_jump=1 and stays set; 9->10 not an error; clr pulse -> err_jump=0, wrap_cnt=0; next transition produces no pulse (INIT).
- WRAPW=2, six up-wraps -> wrap_cnt=3 after the third wrap, wrap_sat=1 from then on, wrap_cnt remains 3.
- Assert rst mid-cycle while wrap_up is high -> wrap_up drops without a clock edge; deassert with count_in 15, next 0 -> no wrap_up (INIT). With COUNT_WRAP_PERIOD_EN, wraps 16 cycles apart -> period=16, period_valid pulse from the second wrap on.
